// File: rtl/seg7_pkg.sv
// +--------------------------------------------------------------------------+
// | seg7_pkg : segment type, active-low glyph constants and polarity helper  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  // Bit order: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g
  typedef logic [6:0] seg_t;

  // Glyphs are stored active-low; a 0 bit lights the segment.
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t seg_polarity(input seg_t seg, input bit active_low);
    return active_low ? seg : ~seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_lut.sv
// +--------------------------------------------------------------------------+
// | seg7_lut : combinational 4-bit digit to active-low glyph lookup          |
// | Optional macro SEG7_HEX_GLYPHS_EN adds glyphs A-F for codes 10-15.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_GLYPHS_EN
      4'd10:   seg = SEG_A;
      4'd11:   seg = SEG_B;
      4'd12:   seg = SEG_C;
      4'd13:   seg = SEG_D;
      4'd14:   seg = SEG_E;
      4'd15:   seg = SEG_F;
`endif
      // Codes without a glyph fall back to a dark digit rather than a fragment.
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_decoder.sv
// +--------------------------------------------------------------------------+
// | seg7_decoder : registered BCD to seven-segment decoder, one HEX digit    |
// | Optional macro SEG7_HEX_GLYPHS_EN (in seg7_lut) shows A-F for 10-15.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] leds
);

  localparam seg_t BLANK_PAT = seg_polarity(SEG_BLANK, ACTIVE_LOW);

  seg_t glyph;
  seg_t leds_d;
  seg_t leds_q;

  seg7_lut u_lut (
    .bcd (bcd),
    .seg (glyph)
  );

  always_comb begin
    leds_d = BLANK_PAT;
    if (!blank) begin
      leds_d = seg_polarity(glyph, ACTIVE_LOW);
    end
  end

  // Reset wins over blank and bcd, so it lives in the register itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= BLANK_PAT;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: directed plan plus random stimulus
// against a segment-list reference model.
`default_nettype none

module tb_seg7_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       blank = 1'b0;
  logic [3:0] bcd_tens = 4'd0;
  logic [3:0] bcd_units = 4'd0;
  logic [6:0] leds_lo, leds_hi, leds_tens, leds_units;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_decoder #(.ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank), .leds(leds_lo));
  seg7_decoder #(.ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank), .leds(leds_hi));
  seg7_decoder u_tens (
    .clk(clk), .reset(reset), .bcd(bcd_tens), .blank(1'b0), .leds(leds_tens));
  seg7_decoder u_units (
    .clk(clk), .reset(reset), .bcd(bcd_units), .blank(1'b0), .leds(leds_units));

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Which segments are lit for each symbol, written as segment letters.
  function automatic string lit_segments(input int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
`ifdef SEG7_HEX_GLYPHS_EN
      10: return "abcefg";
      11: return "cdefg";
      12: return "adef";
      13: return "bcdeg";
      14: return "adefg";
      15: return "aefg";
`endif
      default: return "";
    endcase
  endfunction

  // Active-low pattern expected after an edge that sampled these inputs.
  function automatic logic [6:0] model_lo(input logic r, input logic [3:0] d, input logic b);
    logic [6:0] lit;
    string s;
    lit = '0;
    if (!r && !b) begin
      s = lit_segments(int'(d));
      for (int i = 0; i < s.len(); i++) lit[s[i] - "a"] = 1'b1;
    end
    return ~lit;
  endfunction

  logic [6:0] prev_exp;
  bit         prev_valid = 0;

  // Apply inputs, confirm the output holds until the edge, then check the new value.
  task automatic step(input logic r, input logic [3:0] d, input logic b);
    logic [6:0] e;
    reset = r; bcd = d; blank = b;
    #1;
    if (prev_valid) begin
      check("hold_lo", leds_lo, prev_exp);
      check("hold_hi", leds_hi, ~prev_exp);
    end
    @(posedge clk); #1;
    e = model_lo(r, d, b);
    check($sformatf("lo r=%0d b=%0d bcd=%0d", r, b, d), leds_lo, e);
    check($sformatf("hi r=%0d b=%0d bcd=%0d", r, b, d), leds_hi, ~e);
    prev_exp = e;
    prev_valid = 1;
  endtask

  initial begin
    @(posedge clk); #1;

    // Reset held two cycles with bcd=8, then released
    step(1'b1, 4'd8, 1'b0);
    check("reset_lo_blank", leds_lo, 7'h7F);
    check("reset_hi_blank", leds_hi, 7'h00);
    step(1'b1, 4'd8, 1'b0);
    step(1'b0, 4'd8, 1'b0);
    check("after_reset_8", leds_lo, 7'h00);

    // Consecutive sweep over all codes, in-range and out-of-range
    for (int i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0);

    // Blank behaviour and blank together with reset
    step(1'b0, 4'd5, 1'b1);
    step(1'b0, 4'd5, 1'b0);
    check("unblank_5", leds_lo, 7'h12);
    step(1'b1, 4'd5, 1'b1);

    // Active-high anchors
    step(1'b0, 4'd1, 1'b0);
    check("hi_digit1", leds_hi, 7'h06);
    step(1'b0, 4'd0, 1'b0);
    check("hi_digit0", leds_hi, 7'h3F);

    // Score pairing: 99 then 00
    bcd_tens = 4'd9; bcd_units = 4'd9;
    step(1'b0, 4'd0, 1'b0);
    check("tens_9", leds_tens, model_lo(1'b0, 4'd9, 1'b0));
    check("units_9", leds_units, model_lo(1'b0, 4'd9, 1'b0));
    bcd_tens = 4'd0; bcd_units = 4'd0;
    #1;
    check("tens_hold", leds_tens, model_lo(1'b0, 4'd9, 1'b0));
    step(1'b0, 4'd0, 1'b0);
    check("tens_0", leds_tens, model_lo(1'b0, 4'd0, 1'b0));
    check("units_0", leds_units, model_lo(1'b0, 4'd0, 1'b0));

    // Random stream including mid-stream resets
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
- Registered BCD-to-seven-segment decoder for the board's HEX displays.
- Converts one 4-bit digit (0-9) into a 7-bit segment pattern.
- Instantiated once per display digit, e.g. tens and units digit of the game score.
- Output is registered with 1-cycle latency; polarity is selectable.

Parameters:
- ACTIVE_LOW, default 1: 1 = segment lit when its bit is 0 (board HEX convention); 0 = lit when its bit is 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; clears the output register
- bcd  input  4  digit to display, 0-9 (10-15 handled per Behaviour)
- blank  input  1  1 = all segments off regardless of bcd
- leds  output  7  segment pattern; leds[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Patterns below are active-low (ACTIVE_LOW=1) values of leds[6:0]. With ACTIVE_LOW=0, leds is the bitwise inverse.
  - 0 = 0x40
  - 1 = 0x79
  - 2 = 0x24
  - 3 = 0x30
  - 4 = 0x19
  - 5 = 0x12
  - 6 = 0x02
  - 7 = 0x78
  - 8 = 0x00
  - 9 = 0x10
  - blank (all off) = 0x7F
- Latency: leds reflects the bcd/blank values sampled at rising edge N, starting immediately after edge N (1-cycle registered latency). Between edges, leds holds its value.
- Reset: on a rising edge with reset=1, leds becomes the blank pattern (0x7F active-low, 0x00 active-high). Reset takes priority over blank and bcd, including when asserted mid-stream.
- Priority after reset: blank=1 gives the blank pattern; otherwise decode bcd.
- bcd 10-15 without HEX_EN: blank pattern. Never X; no partial glyphs.
- bcd change on consecutive cycles: each value appears one cycle later, in order; no values are dropped or merged.
- No combinational path from any input to leds.

Optional Feature:
- Macro: SEG7_HEX_GLYPHS_EN.
- Defined: bcd 10-15 decode to hex glyphs (active-low values):
  - A = 0x08
  - b = 0x03
  - C = 0x46
  - d = 0x21
  - E = 0x06
  - F = 0x0E
- Not defined: bcd 10-15 produce the blank pattern.
- Digits 0-9, blank, reset and latency are identical either way.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg_t (logic [6:0])
  - active-low glyph constants SEG_0 through SEG_9, SEG_A through SEG_F, and SEG_BLANK
  - function seg_polarity(seg_t, bit active_low), returning its input or the bitwise inverse.
- One natural sub-module: seg7_lut, a purely combinational 4-bit-to-seg_t lookup that honours SEG7_HEX_GLYPHS_EN.
- seg7_decoder wraps seg7_lut with blank muxing, polarity and the output register.

Test Plan:
- Reset: reset=1 for 2 cycles with bcd=8 -> leds=0x7F throughout; deassert with bcd=8 -> leds=0x00 after the next edge.
- Sweep: bcd=0..9 on consecutive cycles, blank=0 -> leds=0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10, each one cycle after its input.
- Out of range: bcd=10..15 without macro -> 0x7F each cycle; with SEG7_HEX_GLYPHS_EN -> 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E.
- Blank: bcd=5, blank=1 -> 0x7F; drop blank -> 0x12 next cycle. Then blank=1 together with reset=1 -> 0x7F.
- Polarity: ACTIVE_LOW=0, bcd=1 -> 0x06; bcd=0 -> 0x3F; reset -> 0x00.
- Score pairing: two instances fed 99 split into tens=9 and units=9 -> both 0x10. Then 00 -> both 0x40 one cycle later.
